// File: rtl/mc_control_pkg.sv
// Shared constants, state encoding and control-word layout for the
// multi-cycle MIPS main control FSM.
// Optional feature macro: MC_CONTROL_ADDI_EN (adds the addi execute/writeback states).
package mc_control_pkg;

  localparam int unsigned OPCODE_W = 6;
  localparam int unsigned STATE_W  = 4;

  // Instruction opcodes (instr[31:26])
  localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OPCODE_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OPCODE_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OPCODE_W-1:0] OP_J     = 6'b000010;
  localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'b001000;

  // ALU operation requested from the ALU control decoder
  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  // ALU B-operand select
  localparam logic [1:0] ASB_REG_B    = 2'b00;
  localparam logic [1:0] ASB_FOUR     = 2'b01;
  localparam logic [1:0] ASB_IMM      = 2'b10;
  localparam logic [1:0] ASB_IMM_SHL2 = 2'b11;

  // Next-PC source select
  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_ALUOUT = 2'b01;
  localparam logic [1:0] PCS_JUMP   = 2'b10;

  typedef enum logic [STATE_W-1:0] {
    ST_FETCH     = 4'd0,
    ST_DECODE    = 4'd1,
    ST_MEM_ADDR  = 4'd2,
    ST_MEM_READ  = 4'd3,
    ST_MEM_WB    = 4'd4,
    ST_MEM_WRITE = 4'd5,
    ST_R_EXEC    = 4'd6,
    ST_R_WB      = 4'd7,
    ST_BRANCH    = 4'd8,
    ST_JUMP      = 4'd9
`ifdef MC_CONTROL_ADDI_EN
    ,
    ST_ADDI_EXEC = 4'd10,
    ST_ADDI_WB   = 4'd11
`endif
  } state_e;

  // Datapath control word driven every cycle
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       illegal_op;
  } ctrl_t;

  // Control word presented while reset is asserted: FETCH selects, no strobes
  function automatic ctrl_t reset_ctrl();
    ctrl_t c;
    c           = '0;
    c.alu_src_b = ASB_FOUR;
    return c;
  endfunction

endpackage

// File: rtl/mc_main_control.sv
// Multi-cycle MIPS main control FSM: decodes the opcode over several cycles,
// drives datapath selects/strobes, stalls on mem_ready and counts retired
// instructions.
// Optional feature macro: MC_CONTROL_ADDI_EN (addi support via ADDI_EXEC/ADDI_WB).
module mc_main_control
  import mc_control_pkg::*;
#(
  parameter int unsigned RETIRE_CNT_W = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [5:0]              opcode,
  input  logic                    mem_ready,
  output logic                    pc_write,
  output logic                    pc_write_cond,
  output logic                    i_or_d,
  output logic                    mem_read,
  output logic                    mem_write,
  output logic                    ir_write,
  output logic                    mem_to_reg,
  output logic                    reg_dst,
  output logic                    reg_write,
  output logic                    alu_src_a,
  output logic [1:0]              alu_src_b,
  output logic [1:0]              alu_op,
  output logic [1:0]              pc_source,
  output logic                    illegal_op,
  output logic [3:0]              state_dbg,
  output logic [RETIRE_CNT_W-1:0] instr_retired
);

  state_e                  state;
  state_e                  next_state;
  ctrl_t                   ctrl_c;
  logic                    retire_c;
  logic [RETIRE_CNT_W-1:0] retire_cnt;

  // State register; reset wins over any access in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_FETCH;
    end else begin
      state <= next_state;
    end
  end

  // Retired-instruction counter, wraps naturally at 2^RETIRE_CNT_W
  always_ff @(posedge clk) begin
    if (reset) begin
      retire_cnt <= '0;
    end else if (retire_c) begin
      retire_cnt <= retire_cnt + RETIRE_CNT_W'(1);
    end
  end

  // Next-state and Moore control decode (FETCH strobes gated by mem_ready)
  always_comb begin
    next_state = state;
    retire_c   = 1'b0;
    ctrl_c     = '0;

    case (state)
      ST_FETCH: begin
        ctrl_c.mem_read  = 1'b1;
        ctrl_c.alu_src_b = ASB_FOUR;
        ctrl_c.alu_op    = ALU_ADD;
        ctrl_c.pc_source = PCS_ALU;
        if (mem_ready) begin
          ctrl_c.ir_write = 1'b1;
          ctrl_c.pc_write = 1'b1;
          next_state      = ST_DECODE;
        end
      end

      ST_DECODE: begin
        ctrl_c.alu_src_b = ASB_IMM_SHL2;
        ctrl_c.alu_op    = ALU_ADD;
        case (opcode)
          OP_LW, OP_SW: next_state = ST_MEM_ADDR;
          OP_RTYPE:     next_state = ST_R_EXEC;
          OP_BEQ:       next_state = ST_BRANCH;
          OP_J:         next_state = ST_JUMP;
`ifdef MC_CONTROL_ADDI_EN
          OP_ADDI:      next_state = ST_ADDI_EXEC;
`endif
          default: begin
            ctrl_c.illegal_op = 1'b1;
            next_state        = ST_FETCH;
          end
        endcase
      end

      ST_MEM_ADDR: begin
        ctrl_c.alu_src_a = 1'b1;
        ctrl_c.alu_src_b = ASB_IMM;
        ctrl_c.alu_op    = ALU_ADD;
        // Opcode is still held in IR, so the load/store split happens here
        next_state = (opcode == OP_SW) ? ST_MEM_WRITE : ST_MEM_READ;
      end

      ST_MEM_READ: begin
        ctrl_c.mem_read = 1'b1;
        ctrl_c.i_or_d   = 1'b1;
        if (mem_ready) begin
          next_state = ST_MEM_WB;
        end
      end

      ST_MEM_WB: begin
        ctrl_c.reg_write  = 1'b1;
        ctrl_c.mem_to_reg = 1'b1;
        next_state        = ST_FETCH;
        retire_c          = 1'b1;
      end

      ST_MEM_WRITE: begin
        ctrl_c.mem_write = 1'b1;
        ctrl_c.i_or_d    = 1'b1;
        if (mem_ready) begin
          next_state = ST_FETCH;
          retire_c   = 1'b1;
        end
      end

      ST_R_EXEC: begin
        ctrl_c.alu_src_a = 1'b1;
        ctrl_c.alu_src_b = ASB_REG_B;
        ctrl_c.alu_op    = ALU_FUNCT;
        next_state       = ST_R_WB;
      end

      ST_R_WB: begin
        ctrl_c.reg_write = 1'b1;
        ctrl_c.reg_dst   = 1'b1;
        next_state       = ST_FETCH;
        retire_c         = 1'b1;
      end

      ST_BRANCH: begin
        ctrl_c.alu_src_a     = 1'b1;
        ctrl_c.alu_src_b     = ASB_REG_B;
        ctrl_c.alu_op        = ALU_SUB;
        ctrl_c.pc_write_cond = 1'b1;
        ctrl_c.pc_source     = PCS_ALUOUT;
        next_state           = ST_FETCH;
        retire_c             = 1'b1;
      end

      ST_JUMP: begin
        ctrl_c.pc_write  = 1'b1;
        ctrl_c.pc_source = PCS_JUMP;
        next_state       = ST_FETCH;
        retire_c         = 1'b1;
      end

`ifdef MC_CONTROL_ADDI_EN
      ST_ADDI_EXEC: begin
        ctrl_c.alu_src_a = 1'b1;
        ctrl_c.alu_src_b = ASB_IMM;
        ctrl_c.alu_op    = ALU_ADD;
        next_state       = ST_ADDI_WB;
      end

      ST_ADDI_WB: begin
        ctrl_c.reg_write = 1'b1;
        next_state       = ST_FETCH;
        retire_c         = 1'b1;
      end
`endif

      // Unreachable encodings recover to FETCH with everything deasserted
      default: begin
        next_state = ST_FETCH;
      end
    endcase

    if (reset) begin
      ctrl_c   = reset_ctrl();
      retire_c = 1'b0;
    end
  end

  assign pc_write      = ctrl_c.pc_write;
  assign pc_write_cond = ctrl_c.pc_write_cond;
  assign i_or_d        = ctrl_c.i_or_d;
  assign mem_read      = ctrl_c.mem_read;
  assign mem_write     = ctrl_c.mem_write;
  assign ir_write      = ctrl_c.ir_write;
  assign mem_to_reg    = ctrl_c.mem_to_reg;
  assign reg_dst       = ctrl_c.reg_dst;
  assign reg_write     = ctrl_c.reg_write;
  assign alu_src_a     = ctrl_c.alu_src_a;
  assign alu_src_b     = ctrl_c.alu_src_b;
  assign alu_op        = ctrl_c.alu_op;
  assign pc_source     = ctrl_c.pc_source;
  assign illegal_op    = ctrl_c.illegal_op;
  assign state_dbg     = state;
  assign instr_retired = retire_cnt;

endmodule

// File: tb/tb_mc_main_control.sv
// Self-checking bench for mc_main_control: instruction-level reference model
// with randomized opcode mix and memory stalls, plus directed scenarios.
module tb_mc_main_control;

  localparam logic [5:0] T_LW   = 6'b100011;
  localparam logic [5:0] T_SW   = 6'b101011;
  localparam logic [5:0] T_R    = 6'b000000;
  localparam logic [5:0] T_BEQ  = 6'b000100;
  localparam logic [5:0] T_J    = 6'b000010;
  localparam logic [5:0] T_ADDI = 6'b001000;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  opcode;
  logic        mem_ready;

  logic        pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic        mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op;
  logic [1:0]  alu_src_b, alu_op, pc_source;
  logic [3:0]  state_dbg;
  logic [31:0] instr_retired;

  logic        b_pc_write, b_pc_write_cond, b_i_or_d, b_mem_read, b_mem_write, b_ir_write;
  logic        b_mem_to_reg, b_reg_dst, b_reg_write, b_alu_src_a, b_illegal_op;
  logic [1:0]  b_alu_src_b, b_alu_op, b_pc_source;
  logic [3:0]  b_state_dbg;
  logic [1:0]  b_instr_retired;

  int          n_checks = 0;
  int          n_errors = 0;
  int unsigned ret_model = 0;

  mc_main_control dut (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .illegal_op(illegal_op), .state_dbg(state_dbg),
    .instr_retired(instr_retired)
  );

  mc_main_control #(.RETIRE_CNT_W(2)) dut_w2 (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(b_pc_write), .pc_write_cond(b_pc_write_cond), .i_or_d(b_i_or_d),
    .mem_read(b_mem_read), .mem_write(b_mem_write), .ir_write(b_ir_write),
    .mem_to_reg(b_mem_to_reg), .reg_dst(b_reg_dst), .reg_write(b_reg_write),
    .alu_src_a(b_alu_src_a), .alu_src_b(b_alu_src_b), .alu_op(b_alu_op),
    .pc_source(b_pc_source), .illegal_op(b_illegal_op), .state_dbg(b_state_dbg),
    .instr_retired(b_instr_retired)
  );

  always #5 clk = ~clk;

  wire [16:0] obs_vec = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                         mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
                         pc_source, illegal_op};

  function automatic logic [16:0] mkvec(
    input logic pw, input logic pwc, input logic iod, input logic mrd, input logic mwr,
    input logic irw, input logic m2r, input logic rd, input logic rw, input logic asa,
    input logic [1:0] asb, input logic [1:0] aop, input logic [1:0] pcs, input logic ill);
    return {pw, pwc, iod, mrd, mwr, irw, m2r, rd, rw, asa, asb, aop, pcs, ill};
  endfunction

  function automatic bit legal(input logic [5:0] op);
    bit ok;
    ok = (op == T_LW) || (op == T_SW) || (op == T_R) || (op == T_BEQ) || (op == T_J);
`ifdef MC_CONTROL_ADDI_EN
    ok = ok || (op == T_ADDI);
`endif
    return ok;
  endfunction

  // Expected control word for a state as listed in the control table
  function automatic logic [16:0] exp_out(input int st, input logic mr, input logic [5:0] op);
    case (st)
      0:  return mkvec(mr, 0, 0, 1, 0, mr, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 0);
      1:  return mkvec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 2'b00, !legal(op));
      2:  return mkvec(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 2'b00, 0);
      3:  return mkvec(0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0);
      4:  return mkvec(0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 2'b00, 2'b00, 2'b00, 0);
      5:  return mkvec(0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0);
      6:  return mkvec(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b10, 2'b00, 0);
      7:  return mkvec(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 0);
      8:  return mkvec(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 2'b01, 0);
      9:  return mkvec(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b10, 0);
      10: return mkvec(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 2'b00, 0);
      11: return mkvec(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 0);
      default: return '0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, check the expected state/outputs, advance
  task automatic cycle(input int st, input logic mr, input logic [5:0] op);
    mem_ready = mr;
    opcode    = op;
    #1;
    chk($sformatf("state(exp %0d)", st), 32'(state_dbg), 32'(st));
    chk($sformatf("ctrl(st %0d)", st), 32'(obs_vec), 32'(exp_out(st, mr, op)));
    chk("retired", instr_retired, ret_model);
    chk("retired_w2", 32'(b_instr_retired), ret_model % 4);
    @(posedge clk);
    #1;
  endtask

  function automatic logic pick_mr(input bit hi);
    return hi ? 1'b1 : 1'($urandom);
  endfunction

  // Walk one instruction through its expected state path
  task automatic run_instr(input logic [5:0] op, input int fstall, input int mstall, input bit hi);
    for (int i = 0; i < fstall; i++) cycle(0, 1'b0, op);
    cycle(0, 1'b1, op);
    cycle(1, pick_mr(hi), op);
    if (!legal(op)) return;
    if (op == T_LW) begin
      cycle(2, pick_mr(hi), op);
      for (int i = 0; i < mstall; i++) cycle(3, 1'b0, op);
      cycle(3, 1'b1, op);
      cycle(4, pick_mr(hi), op);
    end else if (op == T_SW) begin
      cycle(2, pick_mr(hi), op);
      for (int i = 0; i < mstall; i++) cycle(5, 1'b0, op);
      cycle(5, 1'b1, op);
    end else if (op == T_R) begin
      cycle(6, pick_mr(hi), op);
      cycle(7, pick_mr(hi), op);
    end else if (op == T_BEQ) begin
      cycle(8, pick_mr(hi), op);
    end else if (op == T_J) begin
      cycle(9, pick_mr(hi), op);
    end else begin
      cycle(10, pick_mr(hi), op);
      cycle(11, pick_mr(hi), op);
    end
    ret_model++;
  endtask

  initial begin
    logic [5:0] op;
    reset     = 1'b1;
    mem_ready = 1'b0;
    opcode    = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", 32'(state_dbg), 32'd0);
    chk("reset_ctrl", 32'(obs_vec), 32'(mkvec(0,0,0,0,0,0,0,0,0,0,2'b01,2'b00,2'b00,0)));
    chk("reset_retired", instr_retired, 32'd0);
    reset = 1'b0;

    // Directed instruction cases
    run_instr(T_LW, 0, 0, 1'b1);
    run_instr(T_SW, 0, 3, 1'b0);
    run_instr(T_R, 1, 0, 1'b0);
    run_instr(T_BEQ, 0, 0, 1'b0);
    run_instr(6'b111111, 0, 0, 1'b0);
    run_instr(T_ADDI, 0, 0, 1'b0);
    run_instr(T_LW, 2, 2, 1'b0);

    // Reset during a stalled store
    cycle(0, 1'b1, T_SW);
    cycle(1, 1'b0, T_SW);
    cycle(2, 1'b0, T_SW);
    cycle(5, 1'b0, T_SW);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      mem_ready = 1'b0;
      #1;
      chk("in_reset_ctrl", 32'(obs_vec),
          32'(mkvec(0,0,0,0,0,0,0,0,0,0,2'b01,2'b00,2'b00,0)));
      @(posedge clk);
      #1;
    end
    reset     = 1'b0;
    ret_model = 0;
    cycle(0, 1'b0, T_SW);

    // Four jumps wrap the 2-bit counter: 1,2,3,0
    for (int i = 0; i < 4; i++) run_instr(T_J, 0, 0, 1'b1);
    chk("wrap_w2", 32'(b_instr_retired), 32'd0);
    chk("wrap_w32", instr_retired, 32'd4);

    // Randomized instruction mix
    for (int n = 0; n < 80; n++) begin
      case ($urandom_range(0, 6))
        0: op = T_LW;
        1: op = T_SW;
        2: op = T_R;
        3: op = T_BEQ;
        4: op = T_J;
        5: op = T_ADDI;
        default: begin
          op = 6'($urandom);
          while (legal(op)) op = 6'($urandom);
        end
      endcase
      run_instr(op, $urandom_range(0, 2), $urandom_range(0, 3), 1'b0);
    end
    cycle(0, 1'b0, T_R);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
